// File: rtl/vx_ff_scheduler_pkg.sv
// Shared types and width helpers for the round-robin scheduler and its
// find-first-set helper.
package VX_sched_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   // Index width for an n-entry vector, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter width able to hold the value limit.
   function automatic int wait_cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/vx_ff_scheduler_find_first.sv
// Lowest-index set-bit finder; used for both the rotated round-robin search
// and the starved-requester search.
module VX_find_first
   import VX_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]                req_i,
   output logic                        found_o,
   output logic [idx_width(N)-1:0]     index_o
);

   localparam int IDXW = idx_width(N);

   always_comb begin
      found_o = |req_i;
      index_o = '0;
      // Scanning downward lets the lowest set bit overwrite any higher one.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) index_o = IDXW'(i);
      end
   end

endmodule

// File: rtl/vx_ff_scheduler.sv
// Round-robin N:1 scheduler feeding a single-entry output register.
// Optional starvation control is compiled in with VX_SCHED_STARVE_EN.
module vx_ff_scheduler
   import VX_sched_pkg::*;
#(
   parameter int NUM_REQS     = 4,
   parameter int DATAW        = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic [NUM_REQS-1:0]                valid_in,
   input  logic [NUM_REQS-1:0][DATAW-1:0]     data_in,
   output logic [NUM_REQS-1:0]                ready_in,
   output logic                               valid_out,
   output logic [DATAW-1:0]                   data_out,
   output logic [idx_width(NUM_REQS)-1:0]     index_out,
   input  logic                               ready_out
);

   localparam int IDXW = idx_width(NUM_REQS);

   state_e            state_q, state_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [IDXW-1:0]   index_q, index_d;
   logic [DATAW-1:0]  data_q, data_d;

   logic [NUM_REQS-1:0] rotated;
   logic                rr_found;
   logic [IDXW-1:0]     rr_offset;
   logic [IDXW-1:0]     winner;
   logic                can_take;
   logic                capture;

   function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] a, input int b);
      int s;
      s = (int'(a) + b) % NUM_REQS;
      return s[IDXW-1:0];
   endfunction

   // Bit j of rotated is requester (ptr+j) mod NUM_REQS, so offset 0 is the pointer.
   always_comb begin
      rotated = '0;
      for (int j = 0; j < NUM_REQS; j++) begin
         rotated[j] = valid_in[wrap_add(ptr_q, j)];
      end
   end

   VX_find_first #(.N(NUM_REQS)) u_rr_find (
      .req_i   (rotated),
      .found_o (rr_found),
      .index_o (rr_offset)
   );

`ifdef VX_SCHED_STARVE_EN
   localparam int              CNTW  = wait_cnt_width(STARVE_LIMIT);
   localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

   logic [NUM_REQS-1:0][CNTW-1:0] wait_q, wait_d;
   logic [NUM_REQS-1:0]           starved;
   logic                          st_found;
   logic [IDXW-1:0]               st_index;

   always_comb begin
      starved = '0;
      for (int i = 0; i < NUM_REQS; i++) starved[i] = (wait_q[i] == LIMIT);
   end

   VX_find_first #(.N(NUM_REQS)) u_starve_find (
      .req_i   (starved),
      .found_o (st_found),
      .index_o (st_index)
   );

   // A starved requester is always still valid, so it is a legal winner.
   assign winner = st_found ? st_index : wrap_add(ptr_q, int'(rr_offset));

   always_comb begin
      wait_d = wait_q;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (valid_in[i] && !(capture && winner == IDXW'(i))) begin
            wait_d[i] = (wait_q[i] == LIMIT) ? LIMIT : wait_q[i] + CNTW'(1);
         end else begin
            wait_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) wait_q <= '0;
      else         wait_q <= wait_d;
   end
`else
   localparam int starve_limit_unused = STARVE_LIMIT;

   assign winner = wrap_add(ptr_q, int'(rr_offset));
`endif

   assign can_take = (state_q == EMPTY) | ready_out;
   // Gating with resetn keeps the handshake closed while reset is held.
   assign capture  = resetn & can_take & rr_found;

   always_comb begin
      ready_in = '0;
      if (capture) ready_in[winner] = 1'b1;
   end

   // NOTE: every next-state value gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      index_d = index_q;
      if (capture) begin
         state_d = FULL;
         ptr_d   = wrap_add(winner, 1);
         data_d  = data_in[winner];
         index_d = winner;
      end else if (ready_out) begin
         state_d = EMPTY;
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         index_q <= index_d;
      end
   end

   assign valid_out = (state_q == FULL);
   assign data_out  = data_q;
   assign index_out = index_q;

endmodule

// File: tb/tb_vx_ff_scheduler.sv
// Directed, table-driven bench for vx_ff_scheduler (NUM_REQS=4, DATAW=32);
// the starvation sequence is included when VX_SCHED_STARVE_EN is defined.
module tb_vx_ff_scheduler;

   localparam int NUM_REQS = 4;
   localparam int DATAW    = 32;
   localparam int NVEC     = 14;

   logic                           clk = 1'b0;
   logic                           resetn;
   logic [NUM_REQS-1:0]            valid_in;
   logic [NUM_REQS-1:0][DATAW-1:0] data_in;
   logic [NUM_REQS-1:0]            ready_in;
   logic                           valid_out;
   logic [DATAW-1:0]               data_out;
   logic [1:0]                     index_out;
   logic                           ready_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vx_ff_scheduler #(
      .NUM_REQS     (NUM_REQS),
      .DATAW        (DATAW),
      .STARVE_LIMIT (2)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .index_out (index_out),
      .ready_out (ready_out)
   );

   typedef struct {
      logic [3:0] valid;
      logic       ro;
      logic [3:0] exp_ri;
      logic       exp_vo;
      logic [1:0] exp_idx;
      int         exp_vec;
   } vec_t;

   vec_t tbl [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Payload of requester i during step v is v*256+i, so every capture is traceable.
   task automatic set_data(input int v);
      for (int i = 0; i < NUM_REQS; i++) data_in[i] = 32'(v * 256 + i);
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 3};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4};
      tbl[5]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 5};
      tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 0};
      tbl[7]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 2'd0, 7};
      tbl[8]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 7};
      tbl[9]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 7};
      tbl[10] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 10};
      tbl[11] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 11};
      tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 11};
      tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 0};

      // Reset state, with requests pending to show ready_in is held low.
      resetn    = 1'b0;
      valid_in  = 4'b1111;
      ready_out = 1'b0;
      set_data(0);
      #1;
      check("rst ready_in",  32'(ready_in),  32'h0);
      check("rst valid_out", 32'(valid_out), 32'h0);
      check("rst index_out", 32'(index_out), 32'h0);
      check("rst data_out",  data_out,       32'h0);
      repeat (2) @(negedge clk);
      valid_in = 4'b0000;
      resetn   = 1'b1;

      for (int v = 0; v < NVEC; v++) begin
         @(negedge clk);
         valid_in  = tbl[v].valid;
         ready_out = tbl[v].ro;
         set_data(v);
         #1;
         check($sformatf("v%0d ready_in", v), 32'(ready_in), 32'(tbl[v].exp_ri));
         @(posedge clk);
         #1;
         check($sformatf("v%0d valid_out", v), 32'(valid_out), 32'(tbl[v].exp_vo));
         if (tbl[v].exp_vo) begin
            check($sformatf("v%0d index_out", v), 32'(index_out), 32'(tbl[v].exp_idx));
            check($sformatf("v%0d data_out", v), data_out,
                  32'(tbl[v].exp_vec * 256 + int'(tbl[v].exp_idx)));
         end
      end

      // Mid-transfer reset: pointer is 2 here, so requester 2 is captured first.
      @(negedge clk);
      valid_in  = 4'b1111;
      ready_out = 1'b0;
      set_data(20);
      @(posedge clk);
      #1;
      check("pre-rst valid_out", 32'(valid_out), 32'h1);
      check("pre-rst index_out", 32'(index_out), 32'h2);
      #2;
      resetn = 1'b0;
      #1;
      check("mid-rst valid_out", 32'(valid_out), 32'h0);
      check("mid-rst ready_in",  32'(ready_in),  32'h0);
      check("mid-rst index_out", 32'(index_out), 32'h0);
      check("mid-rst data_out",  data_out,       32'h0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("post-rst ready_in", 32'(ready_in), 32'h1);
      @(posedge clk);
      #1;
      check("post-rst valid_out", 32'(valid_out), 32'h1);
      check("post-rst index_out", 32'(index_out), 32'h0);
      check("post-rst data_out",  data_out,       32'(20 * 256));

`ifdef VX_SCHED_STARVE_EN
      // Requester 3 waits two cycles, then beats round-robin (which would pick 1).
      @(negedge clk);
      resetn   = 1'b0;
      valid_in = 4'b0000;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      valid_in  = 4'b1001;
      ready_out = 1'b1;
      set_data(30);
      #1;
      check("stv A ready_in", 32'(ready_in), 32'h1);
      @(posedge clk);
      #1;
      check("stv A index_out", 32'(index_out), 32'h0);
      @(negedge clk);
      ready_out = 1'b0;
      set_data(31);
      #1;
      check("stv B ready_in", 32'(ready_in), 32'h0);
      @(posedge clk);
      #1;
      check("stv B index_out", 32'(index_out), 32'h0);
      @(negedge clk);
      valid_in  = 4'b1111;
      ready_out = 1'b1;
      set_data(32);
      #1;
      check("stv C ready_in", 32'(ready_in), 32'h8);
      @(posedge clk);
      #1;
      check("stv C index_out", 32'(index_out), 32'h3);
      check("stv C data_out",  data_out,       32'(32 * 256 + 3));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
